// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter with locked bursts and read return routing.
// Define ARB_ROUND_ROBIN_EN for round-robin contention; default is m0 priority.
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_wen,
  output logic              m0_gnt,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rvalid,
  input  logic              m1_req,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_wen,
  output logic              m1_gnt,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rvalid,
  output logic              bus_req,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_wen,
  input  logic [DATA_W-1:0] bus_rdata
);

  localparam int CW = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
  localparam logic [CW-1:0] LIM = CW'(MAX_LOCK - 1);
  localparam logic LOCK_EN = (MAX_LOCK > 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic          rd_pend_q, rd_pend_d;
  logic          rd_owner_q, rd_owner_d;
  logic          beat0, beat1, beat;
  logic          locked, at_lim, hold, pref1;
`ifdef ARB_ROUND_ROBIN_EN
  logic          last_q, last_d;
`endif

  assign m0_gnt = (state_q == OWN0);
  assign m1_gnt = (state_q == OWN1);
  assign beat0  = m0_req & m0_gnt;
  assign beat1  = m1_req & m1_gnt;
  assign beat   = beat0 | beat1;

  // Drive the shared bus from whichever master owns this beat.
  always_comb begin
    bus_req   = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    bus_wen   = 1'b0;
    unique case (1'b1)
      beat0: begin
        bus_req   = 1'b1;
        bus_addr  = m0_addr;
        bus_wdata = m0_wdata;
        bus_wen   = m0_wen;
      end
      beat1: begin
        bus_req   = 1'b1;
        bus_addr  = m1_addr;
        bus_wdata = m1_wdata;
        bus_wen   = m1_wen;
      end
      default: ;
    endcase
  end

  // Lock hold or re-arbitration; forced release prefers the other master.
  always_comb begin
    locked     = ((beat0 & m0_lock) | (beat1 & m1_lock)) & LOCK_EN;
    at_lim     = (lock_cnt_q == LIM);
    hold       = locked & ~at_lim;
`ifdef ARB_ROUND_ROBIN_EN
    last_d     = beat ? beat1 : last_q;
    pref1      = (locked & at_lim) ? beat0 : ~last_d;
`else
    pref1      = locked & at_lim & beat0;
`endif
    state_d    = state_q;
    lock_cnt_d = '0;
    if (hold) begin
      lock_cnt_d = lock_cnt_q + CW'(1);
    end else begin
      unique case ({m0_req, m1_req})
        2'b11:   state_d = pref1 ? OWN1 : OWN0;
        2'b10:   state_d = OWN0;
        2'b01:   state_d = OWN1;
        default: state_d = IDLE;
      endcase
    end
  end

  // A read beat schedules data return to its master next cycle.
  always_comb begin
    rd_pend_d  = beat & ~bus_wen;
    rd_owner_d = beat1;
  end

  assign m0_rvalid = rd_pend_q & ~rd_owner_q;
  assign m1_rvalid = rd_pend_q & rd_owner_q;
  assign m0_rdata  = m0_rvalid ? bus_rdata : '0;
  assign m1_rdata  = m1_rvalid ? bus_rdata : '0;

  // Ownership, lock run length and read-pending state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lock_cnt_q <= '0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Remember who had the latest beat for fair contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random
// traffic checked against a cycle-level behavioural model.
module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int ML = 4;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]    req, lock, wen;
  logic [AW-1:0] addr [2];
  logic [DW-1:0] wdata [2];
  logic [DW-1:0] bus_rdata;
  logic          g0, g1, rv0, rv1, breq, bwen;
  logic [DW-1:0] rd0, rd1, bwd;
  logic [AW-1:0] baddr;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(req[0]), .m0_lock(lock[0]), .m0_addr(addr[0]),
    .m0_wdata(wdata[0]), .m0_wen(wen[0]), .m0_gnt(g0),
    .m0_rdata(rd0), .m0_rvalid(rv0),
    .m1_req(req[1]), .m1_lock(lock[1]), .m1_addr(addr[1]),
    .m1_wdata(wdata[1]), .m1_wen(wen[1]), .m1_gnt(g1),
    .m1_rdata(rd1), .m1_rvalid(rv1),
    .bus_req(breq), .bus_addr(baddr), .bus_wdata(bwd),
    .bus_wen(bwen), .bus_rdata(bus_rdata)
  );

  int checks = 0;
  int failures = 0;

  // reference model: owner (-1 none), beats taken in current locked run,
  // last master served, pending read return
  int own, run, last, pown, last_bm;
  bit pend;

  logic [1:0]    s_gnt, s_rv;
  logic          s_breq, s_wen;
  logic [AW-1:0] s_addr;

  task automatic chk(input string tag, input logic [63:0] o,
                     input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic model_reset();
    own = -1; run = 0; last = 1; pown = 0; pend = 0; last_bm = -1;
  endtask

  task automatic tick();
    int bm, bi;
    bit forced, r0, r1;
    @(negedge clk);
    bm = (own >= 0 && req[own]) ? own : -1;
    bi = (bm < 0) ? 0 : bm;
    r0 = pend && pown == 0;
    r1 = pend && pown == 1;
    chk("gnt0", g0, own == 0);
    chk("gnt1", g1, own == 1);
    chk("bus_req", breq, bm >= 0);
    chk("bus_addr", baddr, (bm >= 0) ? addr[bi] : '0);
    chk("bus_wdata", bwd, (bm >= 0) ? wdata[bi] : '0);
    chk("bus_wen", bwen, (bm >= 0) ? wen[bi] : 1'b0);
    chk("rvalid0", rv0, r0);
    chk("rvalid1", rv1, r1);
    chk("rdata0", rd0, r0 ? bus_rdata : '0);
    chk("rdata1", rd1, r1 ? bus_rdata : '0);
    s_gnt = {g1, g0}; s_rv = {rv1, rv0};
    s_breq = breq; s_wen = bwen; s_addr = baddr;
    @(posedge clk);
    if (rst_n) begin
      pend = (bm >= 0) && !wen[bi];
      pown = bi;
      if (bm >= 0) last = bm;
      if (bm >= 0 && lock[bi] && ML > 1 && run + 1 < ML) begin
        run++;
      end else begin
        forced = (bm >= 0) && lock[bi] && ML > 1;
        run = 0;
        if (req == 2'b11) own = forced ? 1 - bm : (RR ? 1 - last : 0);
        else if (req[0]) own = 0;
        else if (req[1]) own = 1;
        else own = -1;
      end
      last_bm = bm;
    end else begin
      last_bm = -1;
    end
    #1;
    bus_rdata = $urandom;
  endtask

  task automatic quiet();
    req = '0; lock = '0; wen = '0;
    tick(); tick();
  endtask

  task automatic rnd();
    for (int m = 0; m < 2; m++) begin
      if (!(req[m] && last_bm != m && $urandom_range(15) != 0)) begin
        req[m]   = $urandom_range(99) < 60;
        lock[m]  = $urandom_range(3) == 0;
        wen[m]   = 1'($urandom_range(1));
        addr[m]  = $urandom;
        wdata[m] = $urandom;
      end
    end
  endtask

  initial begin
    int prev, cur;
    model_reset();
    req = '0; lock = '0; wen = '0; bus_rdata = '0;
    addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
    tick(); tick();
    chk("reset_gnt", s_gnt, 2'b00);
    chk("reset_busreq", s_breq, 1'b0);
    rst_n = 1'b1;

    // single read from idle
    req[0] = 1'b1; addr[0] = 32'h1000_0010;
    tick();
    chk("rd_c0_gnt", s_gnt, 2'b00);
    tick();
    chk("rd_c1_gnt", s_gnt, 2'b01);
    chk("rd_c1_addr", s_addr, 32'h1000_0010);
    req[0] = 1'b0;
    tick();
    chk("rd_c2_rv", s_rv, 2'b01);
    quiet();

    // write pass-through on m1
    req[1] = 1'b1; wen[1] = 1'b1;
    addr[1] = 32'h2000_0000; wdata[1] = 32'hA5;
    tick(); tick();
    chk("wr_wen", s_wen, 1'b1);
    req[1] = 1'b0;
    tick();
    chk("wr_wen_off", s_wen, 1'b0);
    chk("wr_no_rv", s_rv, 2'b00);
    tick();
    chk("wr_no_rv2", s_rv, 2'b00);
    quiet();

    // request withdrawal hands straight to m1
    req[0] = 1'b1; addr[0] = 32'h44;
    tick();
    req[0] = 1'b0; req[1] = 1'b1; addr[1] = 32'h88;
    tick();
    chk("wd_nobeat", s_breq, 1'b0);
    tick();
    chk("wd_gnt1", s_gnt, 2'b10);
    req[1] = 1'b0;
    quiet();

    // lock limit: four m1 beats then m0
    req[1] = 1'b1; lock[1] = 1'b1;
    tick();
    req[0] = 1'b1;
    for (int i = 0; i < ML; i++) begin
      tick();
      chk("lock_m1_beat", {s_breq, s_gnt}, 3'b110);
    end
    tick();
    chk("lock_m0_next", s_gnt, 2'b01);
    quiet();

    // contention, unlocked
    req = 2'b11;
    tick();
    prev = -1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("cont_beat", s_breq, 1'b1);
      cur = s_gnt[1] ? 1 : 0;
      if (RR) begin
        if (prev >= 0) chk("rr_alternate", cur, 1 - prev);
      end else begin
        chk("fp_no_m1", s_gnt[1], 1'b0);
      end
      prev = cur;
    end
    quiet();

    // reset with a read pending
    req[0] = 1'b1; addr[0] = 32'h30;
    tick(); tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_rv0", rv0, 1'b0);
    chk("rst_gnt0", g0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", s_gnt, 2'b00);
    tick();
    chk("post_rst_gnt", s_gnt, 2'b01);
    req[0] = 1'b0;
    quiet();

    // random traffic
    for (int i = 0; i < 500; i++) begin
      rnd();
      tick();
    end
    quiet();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
